// File: rtl/stack_ctrl.sv
// Stack sequencer for PUSH/POP/CALL/RET: one memory access over req/ack, then
// one-at-a-time register-bank writes (popped value, new SP) and PC loads.
module stack_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int SP_IDX    = 16,
    parameter int STACK_TOP = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] push_data,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] pc_next,
    input  logic [DATA_W-1:0] target,
    input  logic [DATA_W-1:0] sp_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [4:0]        rf_addr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_val
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MEM   = 3'd1,
        WB_RD = 3'd2,
        WB_SP = 3'd3,
        FIN   = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [1:0]        OP_POP = 2'b01;
    localparam logic [1:0]        OP_RET = 2'b11;
    localparam logic [ADDR_W-1:0] TOP    = ADDR_W'(STACK_TOP);
    localparam logic [4:0]        SP_REG = 5'(SP_IDX);

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [ADDR_W-1:0] sp_q, sp_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              rf_we_q, rf_we_d, pc_load_q, pc_load_d;
    logic [4:0]        rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d, pc_val_q, pc_val_d;

    logic [ADDR_W-1:0] sp_in_s;
    logic [ADDR_W-1:0] sp_new_s;
    logic [DATA_W-1:0] sp_new_ext_s;
    logic              unused_sp_hi_s;

    // Only the low ADDR_W bits of the incoming SP address the stack
    assign sp_in_s        = sp_in[ADDR_W-1:0];
    assign unused_sp_hi_s = ^sp_in[DATA_W-1:ADDR_W];
    // op[0] = 0 marks the pushing ops (PUSH/CALL), which move SP down
    assign sp_new_s       = op_q[0] ? (sp_q + ADDR_W'(1)) : (sp_q - ADDR_W'(1));
    assign sp_new_ext_s   = {{(DATA_W-ADDR_W){1'b0}}, sp_new_s};

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        target_d    = target_q;
        sp_d        = sp_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rf_we_d     = 1'b0;
        pc_load_d   = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rf_addr_d   = rf_addr_q;
        rf_wdata_d  = rf_wdata_q;
        pc_val_d    = pc_val_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d     = op;
                    rd_d     = rd;
                    target_d = target;
                    sp_d     = sp_in_s;
                    if ((!op[0] && (sp_in_s == {ADDR_W{1'b0}})) || (op[0] && (sp_in_s == TOP))) begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end else begin
                        state_d     = MEM;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~op[0];
                        mem_addr_d  = op[0] ? (sp_in_s + ADDR_W'(1)) : sp_in_s;
                        mem_wdata_d = op[0] ? mem_wdata_q : (op[1] ? pc_next : push_data);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (op_q == OP_POP) begin
                        state_d    = WB_RD;
                        rf_we_d    = (rd_q != 5'd0);
                        rf_addr_d  = rd_q;
                        rf_wdata_d = mem_rdata;
                    end else begin
                        state_d    = WB_SP;
                        rf_we_d    = 1'b1;
                        rf_addr_d  = SP_REG;
                        rf_wdata_d = sp_new_ext_s;
                        pc_load_d  = op_q[1];
                        pc_val_d   = op_q[1] ? ((op_q == OP_RET) ? mem_rdata : target_q) : pc_val_q;
                    end
                end else begin
                    state_d = MEM;
                end
            end
            WB_RD: begin
                state_d    = WB_SP;
                rf_we_d    = 1'b1;
                rf_addr_d  = SP_REG;
                rf_wdata_d = sp_new_ext_s;
            end
            WB_SP: begin
                state_d = FIN;
                done_d  = 1'b1;
            end
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, operation context and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            rd_q        <= 5'd0;
            target_q    <= {DATA_W{1'b0}};
            sp_q        <= {ADDR_W{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rf_we_q     <= 1'b0;
            rf_addr_q   <= 5'd0;
            rf_wdata_q  <= {DATA_W{1'b0}};
            pc_load_q   <= 1'b0;
            pc_val_q    <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            target_q    <= target_d;
            sp_q        <= sp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_wdata_q  <= rf_wdata_d;
            pc_load_q   <= pc_load_d;
            pc_val_q    <= pc_val_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wdata  = rf_wdata_q;
    assign pc_load   = pc_load_q;
    assign pc_val    = pc_val_q;
endmodule
